// File: rtl/dmem_responder.sv
// Word-organised data-memory slave with a programmable wait-state request FSM.
// Optional out-of-range flag port mem_err is built when DMEM_ERR_EN is defined.
module dmem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_r_enable,
    input  logic              mem_w_enable,
    input  logic [DATA_W-1:0] mem_w_data,
    output logic [DATA_W-1:0] mem_r_data,
    output logic              mem_ready
`ifdef DMEM_ERR_EN
    ,
    output logic              mem_err
`endif
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;

    logic [DATA_W-1:0] ram [DEPTH_WORDS];

    logic              req;
    logic [ADDR_W-1:0] cmd_idx;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_wr;
    logic              go_resp;
    logic              in_range;

    // With LATENCY==1 the commit edge is the request edge itself, so the
    // command is taken straight from the inputs while still in IDLE.
    always_comb begin
        req = mem_r_enable | mem_w_enable;
        if (state == IDLE) begin
            cmd_idx  = mem_addr >> 2;
            cmd_data = mem_w_data;
            cmd_wr   = mem_w_enable;
        end else begin
            cmd_idx  = idx_q;
            cmd_data = wdata_q;
            cmd_wr   = wr_q;
        end
        go_resp  = ((state == IDLE) && req && (LATENCY == 1)) ||
                   ((state == WAIT) && (cnt == 4'd1));
        in_range = (cmd_idx >> AW) == '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            mem_ready  <= 1'b0;
            mem_r_data <= '0;
`ifdef DMEM_ERR_EN
            mem_err    <= 1'b0;
`endif
        end else begin
            mem_ready <= go_resp;
`ifdef DMEM_ERR_EN
            mem_err   <= go_resp && !in_range;
`endif
            if (go_resp && !cmd_wr)
                mem_r_data <= in_range ? ram[cmd_idx[AW-1:0]] : '0;

            case (state)
                IDLE: begin
                    if (req) begin
                        idx_q   <= mem_addr >> 2;
                        wdata_q <= mem_w_data;
                        wr_q    <= mem_w_enable;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Writes commit on the edge entering RESP; a reset on that edge cancels them.
    always_ff @(posedge clk) begin
        if (!reset && go_resp && cmd_wr && in_range)
            ram[cmd_idx[AW-1:0]] <= cmd_data;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 4) against a timeline model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst  [2];
    logic        ren  [2];
    logic        wen  [2];
    logic [31:0] addr [2];
    logic [31:0] wd   [2];
    logic [31:0] rdata[2];
    logic        rdy  [2];
    logic        errs [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(2)) dut0 (
        .clk(clk), .reset(rst[0]), .mem_addr(addr[0]), .mem_r_enable(ren[0]),
        .mem_w_enable(wen[0]), .mem_w_data(wd[0]), .mem_r_data(rdata[0]), .mem_ready(rdy[0])
`ifdef DMEM_ERR_EN
        , .mem_err(errs[0])
`endif
    );

    dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(4)) dut1 (
        .clk(clk), .reset(rst[1]), .mem_addr(addr[1]), .mem_r_enable(ren[1]),
        .mem_w_enable(wen[1]), .mem_w_data(wd[1]), .mem_r_data(rdata[1]), .mem_ready(rdy[1])
`ifdef DMEM_ERR_EN
        , .mem_err(errs[1])
`endif
    );

`ifndef DMEM_ERR_EN
    assign errs[0] = 1'b0;
    assign errs[1] = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timeline model: a request accepted in cycle c completes in cycle c+lat;
    // the completion cycle itself is deaf to requests.
    bit          pend   [2];
    int          due    [2];
    int          resp_c [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_data [2];
    bit          p_wr   [2];
    logic        exp_rdy[2];
    logic [31:0] exp_rd [2];
    logic        exp_err[2];
    bit          mvalid [2];
    logic [31:0] mem [longint];

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                pend[i] = 0; exp_rdy[i] = 1'b0; exp_rd[i] = '0; exp_err[i] = 1'b0;
                resp_c[i] = -1; mvalid[i] = 1;
            end else if (mvalid[i]) begin
                exp_rdy[i] = 1'b0;
                exp_err[i] = 1'b0;
                if (!pend[i] && cyc > resp_c[i] && (ren[i] || wen[i])) begin
                    pend[i] = 1; due[i] = cyc + lat_of(i);
                    p_addr[i] = addr[i]; p_data[i] = wd[i]; p_wr[i] = wen[i];
                end
                if (pend[i] && due[i] == cyc + 1) begin
                    logic [31:0] idx;
                    longint      key;
                    idx = p_addr[i] >> 2;
                    key = (longint'(i) << 32) | longint'(idx);
                    exp_rdy[i] = 1'b1;
                    exp_err[i] = (idx >= 32'd1024);
                    pend[i]    = 0;
                    resp_c[i]  = cyc + 1;
                    if (p_wr[i]) begin
                        if (idx < 32'd1024) mem[key] = p_data[i];
                    end else begin
                        exp_rd[i] = (idx < 32'd1024) ? mem[key] : 32'h0;
                    end
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mvalid[i]) begin
                chk($sformatf("ready%0d", i), {31'd0, rdy[i]}, {31'd0, exp_rdy[i]});
                chk($sformatf("rdata%0d", i), rdata[i], exp_rd[i]);
`ifdef DMEM_ERR_EN
                chk($sformatf("err%0d", i), {31'd0, errs[i]}, {31'd0, exp_err[i]});
`endif
            end
        end
    end

    task automatic txn(input int i, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output logic [31:0] rd,
                       output logic e);
        int k;
        @(posedge clk); #1;
        k = cyc; ren[i] = r; wen[i] = w; addr[i] = a; wd[i] = d;
        lat = -1; rd = 'x; e = 1'bx;
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            if (rdy[i] === 1'b1) begin
                lat = cyc - k; rd = rdata[i]; e = errs[i];
                break;
            end
        end
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL txn_timeout: got no ready, required ready within 32 cycles");
        end
        @(posedge clk); #1;
        ren[i] = 1'b0; wen[i] = 1'b0;
    endtask

    initial begin
        int          lat, k, nr, c1, c2;
        logic [31:0] rd;
        logic        e;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; ren[i] = 1'b0; wen[i] = 1'b0; addr[i] = '0; wd[i] = '0;
            mvalid[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1; rst[0] = 1'b0; rst[1] = 1'b0;

        nr = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rdy[0] !== 1'b0 || rdy[1] !== 1'b0) nr++;
        end
        chk("idle_ready_count", nr, 0);
        chk("idle_rdata", rdata[0], 32'h0);

        txn(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, e);
        chk("wr_latency", lat, 2);
        txn(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, rd, e);
        chk("rd_latency", lat, 2);
        chk("rd_data", rd, 32'hDEADBEEF);

        @(posedge clk); #1;
        k = cyc; ren[0] = 1'b1; addr[0] = 32'h13;
        nr = 0; c1 = -1; c2 = -1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (rdy[0] === 1'b1) begin
                if (nr == 0) c1 = cyc - k; else c2 = cyc - k;
                nr++;
                chk("hold_data", rdata[0], 32'hDEADBEEF);
            end
        end
        @(posedge clk); #1; ren[0] = 1'b0;
        chk("hold_count", nr, 2);
        chk("hold_first", c1, 2);
        chk("hold_second", c2, 5);

        txn(0, 1'b0, 1'b1, 32'h0, 32'hCAFE0000, lat, rd, e);
        txn(0, 1'b0, 1'b1, 32'h1000, 32'h1234, lat, rd, e);
        chk("oor_wr_latency", lat, 2);
`ifdef DMEM_ERR_EN
        chk("oor_wr_err", {31'd0, e}, 32'd1);
`endif
        txn(0, 1'b1, 1'b0, 32'h1000, 32'h0, lat, rd, e);
        chk("oor_rd_data", rd, 32'h0);
`ifdef DMEM_ERR_EN
        chk("oor_rd_err", {31'd0, e}, 32'd1);
`endif
        txn(0, 1'b1, 1'b0, 32'h0, 32'h0, lat, rd, e);
        chk("ram0_unchanged", rd, 32'hCAFE0000);
`ifdef DMEM_ERR_EN
        chk("inrange_err", {31'd0, e}, 32'd0);
`endif

        txn(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, rd, e);
        txn(0, 1'b1, 1'b1, 32'h20, 32'h55, lat, rd, e);
        chk("both_en_rdata_held", rd, 32'hDEADBEEF);
        txn(0, 1'b1, 1'b0, 32'h20, 32'h0, lat, rd, e);
        chk("both_en_written", rd, 32'h55);

        txn(1, 1'b0, 1'b1, 32'h30, 32'hA5A5, lat, rd, e);
        chk("lat4_wr_latency", lat, 4);
        @(posedge clk); #1;
        wen[1] = 1'b1; addr[1] = 32'h30; wd[1] = 32'h1111;
        @(posedge clk); #1;
        rst[1] = 1'b1; wen[1] = 1'b0;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        nr = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (rdy[1] !== 1'b0) nr++;
        end
        chk("abort_no_ready", nr, 0);
        txn(1, 1'b1, 1'b0, 32'h30, 32'h0, lat, rd, e);
        chk("after_reset_latency", lat, 4);
        chk("abort_ram_unchanged", rd, 32'hA5A5);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule
